// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: valid/ready inter-stage register with stall, flush-to-bubble, optional skid entry
module pipeline_stage_register #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    CTRL_WIDTH  = 16,
   parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
   parameter bit                    SKID_EN     = 1'b1,
   parameter int                    COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [DATA_WIDTH-1:0]  inData,
   input  logic [CTRL_WIDTH-1:0]  inCtrl,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [DATA_WIDTH-1:0]  outData,
   output logic [CTRL_WIDTH-1:0]  outCtrl,
   output logic [COUNT_WIDTH-1:0] killedCount
);
   logic                   head_valid, skid_valid;
   logic [DATA_WIDTH-1:0]  skid_data;
   logic [CTRL_WIDTH-1:0]  skid_ctrl;
   logic                   in_fire, out_fire, load_in, load_skid, fill_skid, drain;
   logic [COUNT_WIDTH:0]   kill_sum;
   // handshake decode; the head is never emitted in a flush cycle, so an entry is either delivered or killed
   always_comb begin
      inReady   = resetN & (flush | (!stall & (SKID_EN ? !(head_valid & skid_valid) : (!head_valid | outReady))));
      outValid  = head_valid & !stall & !flush;
      in_fire   = inValid & inReady & !stall & !flush;
      out_fire  = outValid & outReady;
      load_skid = out_fire & skid_valid;
      fill_skid = SKID_EN & in_fire & head_valid & !out_fire;
      load_in   = in_fire & !fill_skid;
      drain     = out_fire & !skid_valid & !in_fire;
      kill_sum  = {1'b0, killedCount} + (COUNT_WIDTH+1)'(head_valid) + (COUNT_WIDTH+1)'(skid_valid);
   end
   // occupancy, head control field and flush accounting
   always_ff @(posedge clock or negedge resetN)
      if (!resetN) begin
         head_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         outCtrl     <= CTRL_BUBBLE;
         killedCount <= '0;
      end else if (flush) begin
         head_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         outCtrl     <= CTRL_BUBBLE;
         killedCount <= kill_sum[COUNT_WIDTH] ? '1 : kill_sum[COUNT_WIDTH-1:0];
      end else begin
         head_valid <= load_in | load_skid | (head_valid & !drain);
         skid_valid <= fill_skid | (skid_valid & !load_skid);
         if (load_in) outCtrl <= inCtrl;
         else if (load_skid) outCtrl <= skid_ctrl;
         else if (drain) outCtrl <= CTRL_BUBBLE;
      end
   // payload registers change only when an entry is captured
   always_ff @(posedge clock or negedge resetN)
      if (!resetN) begin
         outData   <= '0;
         skid_data <= '0;
         skid_ctrl <= CTRL_BUBBLE;
      end else if (!flush) begin
         if (load_in) outData <= inData;
         else if (load_skid) outData <= skid_data;
         if (fill_skid) begin
            skid_data <= inData;
            skid_ctrl <= inCtrl;
         end
      end
endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb_pipeline_stage_register: scoreboard bench over three configurations (skid, no skid, 2-bit counter)
module tb_pipeline_stage_register;
   typedef struct {
      logic [31:0] d;
      logic [15:0] c;
   } ent_t;
   logic        clock = 1'b0;
   logic        rn   [3];
   logic        iv   [3];
   logic        stl  [3];
   logic        fls  [3];
   logic        ordy [3];
   logic [31:0] idt  [3];
   logic [15:0] ict  [3];
   ent_t        q    [3][$];
   int          kill_exp [3];
   int          checks   = 0;
   int          failures = 0;
   always #5 clock = ~clock;
   function automatic bit skid_of(input int k);
      return k != 1;
   endfunction
   function automatic logic [15:0] bub(input int k);
      return (k == 0) ? 16'h5A5A : 16'h0000;
   endfunction
   function automatic int sat(input int k, input int x);
      int m;
      m = (k == 2) ? 3 : 255;
      return (x > m) ? m : x;
   endfunction
   // stage can take an entry when it holds fewer than its capacity (or the head is leaving, without skid)
   function automatic bit exp_ready(input int k);
      int n;
      n = q[k].size();
      if (!rn[k]) return 1'b0;
      if (fls[k]) return 1'b1;
      if (stl[k]) return 1'b0;
      return skid_of(k) ? (n < 2) : (n == 0 || ordy[k]);
   endfunction
   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, k, act, exp, $time);
      end
   endtask
   task automatic mon(input int k, input logic ovv, input logic irv, input logic [31:0] odv,
                      input logic [15:0] ocv, input logic [7:0] kcv);
      int n;
      n = q[k].size();
      chk(k, "outValid", 32'(ovv), 32'(rn[k] && n > 0 && !stl[k] && !fls[k]));
      chk(k, "inReady", 32'(irv), 32'(exp_ready(k)));
      chk(k, "outCtrl", 32'(ocv), 32'((n > 0) ? q[k][0].c : bub(k)));
      chk(k, "killedCount", 32'(kcv), 32'(kill_exp[k]));
      if (n > 0 && rn[k]) chk(k, "outData", odv, q[k][0].d);
      if (ovv && ordy[k] && n > 0) void'(q[k].pop_front());
   endtask
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int          CW = (g == 2) ? 2 : 8;
      localparam logic [15:0] BB = (g == 0) ? 16'h5A5A : 16'h0000;
      logic          ovw, irw;
      logic [31:0]   odw;
      logic [15:0]   ocw;
      logic [CW-1:0] kcw;
      pipeline_stage_register #(
         .DATA_WIDTH(32), .CTRL_WIDTH(16), .CTRL_BUBBLE(BB), .SKID_EN(g != 1), .COUNT_WIDTH(CW)
      ) dut (
         .clock(clock), .resetN(rn[g]), .inValid(iv[g]), .inReady(irw), .inData(idt[g]), .inCtrl(ict[g]),
         .stall(stl[g]), .flush(fls[g]), .outValid(ovw), .outReady(ordy[g]), .outData(odw),
         .outCtrl(ocw), .killedCount(kcw)
      );
      initial forever begin
         @(posedge clock);
         #4;
         mon(g, ovw, irw, odw, ocw, 8'(kcw));
      end
   end
   // one cycle of stimulus; the expected entry is queued (or the queue flushed) once the cycle is judged
   task automatic step(input int k, input bit v, input logic [31:0] d, input logic [15:0] c,
                       input bit st, input bit fl, input bit ordv, output bit acc);
      ent_t e;
      @(posedge clock);
      #1;
      iv[k] = v; idt[k] = d; ict[k] = c; stl[k] = st; fls[k] = fl; ordy[k] = ordv;
      acc = v && exp_ready(k) && !st && !fl;
      #4;
      if (fl) begin
         kill_exp[k] = sat(k, kill_exp[k] + q[k].size());
         q[k].delete();
      end else if (acc) begin
         e.d = d;
         e.c = c;
         q[k].push_back(e);
      end
   endtask
   task automatic idle(input int k, input int n, input bit ordv);
      bit a;
      for (int i = 0; i < n; i++) step(k, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, ordv, a);
   endtask
   task automatic rand_run(input int k, input int n);
      bit a;
      for (int i = 0; i < n; i++)
         step(k, $urandom_range(9, 0) < 7, $urandom, 16'($urandom), $urandom_range(9, 0) == 0,
              $urandom_range(19, 0) == 0, $urandom_range(9, 0) < 6, a);
   endtask
   task automatic script_skid();
      bit a;
      for (int i = 1; i <= 8; i++) step(0, 1'b1, i, 16'(i + 16'h100), 1'b0, 1'b0, 1'b1, a);
      idle(0, 2, 1'b1);
      step(0, 1'b1, 32'hA, 16'h00A1, 1'b0, 1'b0, 1'b0, a);
      step(0, 1'b1, 32'hB, 16'h00B1, 1'b0, 1'b0, 1'b0, a);
      step(0, 1'b1, 32'hC, 16'h00C1, 1'b0, 1'b0, 1'b0, a);
      step(0, 1'b1, 32'hC, 16'h00C1, 1'b0, 1'b0, 1'b0, a);
      a = 1'b0;
      for (int i = 0; i < 6 && !a; i++) step(0, 1'b1, 32'hC, 16'h00C1, 1'b0, 1'b0, 1'b1, a);
      idle(0, 4, 1'b1);
      step(0, 1'b1, 32'hD, 16'h00D1, 1'b0, 1'b0, 1'b0, a);
      step(0, 1'b1, 32'hE, 16'h00E1, 1'b0, 1'b0, 1'b0, a);
      step(0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, a);
      step(0, 1'b1, 32'hF, 16'h00F1, 1'b0, 1'b1, 1'b1, a);
      idle(0, 3, 1'b1);
      step(0, 1'b1, 32'h77, 16'h0771, 1'b0, 1'b0, 1'b1, a);
      for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h88, 16'h0881, 1'b1, 1'b0, 1'b1, a);
      idle(0, 3, 1'b1);
      rand_run(0, 500);
   endtask
   task automatic script_noskid();
      bit a;
      step(1, 1'b1, 32'h11, 16'h0011, 1'b0, 1'b0, 1'b0, a);
      step(1, 1'b1, 32'h12, 16'h0012, 1'b0, 1'b0, 1'b0, a);
      step(1, 1'b1, 32'h12, 16'h0012, 1'b0, 1'b0, 1'b1, a);
      for (int i = 1; i <= 8; i++) step(1, 1'b1, 32'h20 + i, 16'(i), 1'b0, 1'b0, 1'b1, a);
      idle(1, 2, 1'b1);
      rand_run(1, 500);
   endtask
   task automatic script_sat();
      bit a;
      for (int r = 0; r < 3; r++) begin
         step(2, 1'b1, 32'h30 + r, 16'h0031, 1'b0, 1'b0, 1'b0, a);
         step(2, 1'b1, 32'h40 + r, 16'h0041, 1'b0, 1'b0, 1'b0, a);
         step(2, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, a);
         step(2, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, a);
      end
      step(2, 1'b1, 32'h55, 16'h0055, 1'b0, 1'b0, 1'b0, a);
      step(2, 1'b1, 32'h66, 16'h0066, 1'b0, 1'b0, 1'b0, a);
      step(2, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, a);
      #2;
      rn[2] = 1'b0;
      q[2].delete();
      kill_exp[2] = 0;
      #1;
      chk(2, "rst_outValid", 32'(u[2].ovw), 32'h0);
      chk(2, "rst_outCtrl", 32'(u[2].ocw), 32'(bub(2)));
      chk(2, "rst_killed", 32'(u[2].kcw), 32'h0);
      chk(2, "rst_outData", u[2].odw, 32'h0);
      idle(2, 2, 1'b1);
      #2;
      rn[2] = 1'b1;
      rand_run(2, 400);
   endtask
   initial begin
      for (int k = 0; k < 3; k++) begin
         rn[k] = 1'b0; iv[k] = 1'b0; stl[k] = 1'b0; fls[k] = 1'b0; ordy[k] = 1'b0;
         idt[k] = '0; ict[k] = '0; kill_exp[k] = 0;
      end
      #27;
      for (int k = 0; k < 3; k++) rn[k] = 1'b1;
      fork
         script_skid();
         script_noskid();
         script_sat();
      join
      @(posedge clock);
      #6;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
